// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead adder/subtractor, one GROUP-bit slice per stage
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; in_ready = !out_valid | out_ready
//   a, b [WIDTH]          operands
//   cin                   carry-in for add (ignored when sub=1)
//   sub                   0: a+b+cin, 1: a-b (a + ~b + 1)
//   sat                   clamp to signed max/min on overflow (only with CLA_PIPE_SAT_EN)
//   out_valid / out_ready result handshake
//   sum [WIDTH]           result modulo 2^WIDTH
//   cout                  carry-out; for sub, 1 = no borrow
//   ovf                   signed overflow (carry into MSB xor cout)
//   zero                  sum == 0
//
// Optional feature macro: CLA_PIPE_SAT_EN adds the sat input and saturating sum.
module cla_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef CLA_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSTG = WIDTH / GROUP;

    logic             vld_q [NSTG];
    logic             vld_d [NSTG];
    logic [WIDTH-1:0] s_q   [NSTG];
    logic [WIDTH-1:0] s_d   [NSTG];
    logic [WIDTH-1:0] a_q   [NSTG];
    logic [WIDTH-1:0] a_d   [NSTG];
    logic [WIDTH-1:0] b_q   [NSTG];
    logic [WIDTH-1:0] b_d   [NSTG];
    logic             c_q   [NSTG];
    logic             c_d   [NSTG];
`ifdef CLA_PIPE_SAT_EN
    logic             sat_q [NSTG];
    logic             sat_d [NSTG];
`endif
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             adv;

    // Flat lookahead: each carry is a sum of products of g/p terms and the
    // slice carry-in, so no carry depends on a lower carry inside the slice.
    function automatic logic [GROUP:0] cla(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             ci
    );
        logic [GROUP:0]   c;
        logic [GROUP-1:0] m;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            m        = GROUP'((1 << (i + 1)) - 1);
            c[i + 1] = ci & (&(p | ~m));
            for (int j = 0; j <= i; j++) begin
                m        = GROUP'((1 << (i + 1)) - (1 << (j + 1)));
                c[i + 1] = c[i + 1] | (g[j] & (&(p | ~m)));
            end
        end
        return c;
    endfunction

    assign adv       = !out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[NSTG-1];
    assign sum       = s_q[NSTG-1];
    assign cout      = c_q[NSTG-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    always_comb begin
        logic [WIDTH-1:0] sa, sb, ss;
        logic             sc;
        logic [GROUP-1:0] g, p;
        logic [GROUP:0]   cc;
        int               j;
`ifdef CLA_PIPE_SAT_EN
        logic             st;
`endif
        ovf_d  = 1'b0;
        zero_d = 1'b0;
        for (int k = 0; k < NSTG; k++) begin
            j  = (k > 0) ? k - 1 : 0;
            // Stage 0 takes the raw operands; B is inverted once here for sub.
            sa = (k == 0) ? a : a_q[j];
            sb = (k == 0) ? (sub ? ~b : b) : b_q[j];
            sc = (k == 0) ? (sub | cin) : c_q[j];
            ss = (k == 0) ? '0 : s_q[j];
            g  = sa[k*GROUP +: GROUP] & sb[k*GROUP +: GROUP];
            p  = sa[k*GROUP +: GROUP] ^ sb[k*GROUP +: GROUP];
            cc = cla(g, p, sc);
            ss[k*GROUP +: GROUP] = p ^ cc[GROUP-1:0];
            vld_d[k] = (k == 0) ? in_valid : vld_q[j];
            a_d[k]   = sa;
            b_d[k]   = sb;
            c_d[k]   = cc[GROUP];
`ifdef CLA_PIPE_SAT_EN
            st       = (k == 0) ? sat : sat_q[j];
            sat_d[k] = st;
`endif
            if (k == NSTG - 1) begin
                ovf_d = cc[GROUP] ^ cc[GROUP-1];
`ifdef CLA_PIPE_SAT_EN
                // Clamp direction follows the sign of the original A operand.
                if (st && ovf_d)
                    ss = {sa[WIDTH-1], {(WIDTH-1){~sa[WIDTH-1]}}};
`endif
                zero_d = ~|ss;
            end
            s_d[k] = ss;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                vld_q[k] <= 1'b0;
                s_q[k]   <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                c_q[k]   <= 1'b0;
`ifdef CLA_PIPE_SAT_EN
                sat_q[k] <= 1'b0;
`endif
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NSTG; k++) begin
                vld_q[k] <= vld_d[k];
                s_q[k]   <= s_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                c_q[k]   <= c_d[k];
`ifdef CLA_PIPE_SAT_EN
                sat_q[k] <= sat_d[k];
`endif
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end
endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Generalises the existing fixed 8-bit combinational CLA to any width, with add/subtract mode, carry-in and status flags.
- Operand word is split into GROUP-bit lookahead slices, one slice resolved per pipeline stage; the inter-group carry is registered between stages.
- Sits between an operand source and a result consumer, with valid/ready handshakes on both sides. Throughput is one operation per cycle.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of GROUP, >= GROUP.
- GROUP, 4, bits per lookahead slice, i.e. per pipeline stage; 2..8.
- NSTG, WIDTH/GROUP (derived localparam), number of pipeline stages = latency in cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand word valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry-out; for sub, 1 = no borrow (A >= B unsigned).
- ovf  out  1  signed overflow = carry into MSB XOR cout.
- zero  out  1  sum == 0.

Behaviour:
- Reset (async assert, sync release):
  - All stage valid bits and data registers clear.
  - Outputs: out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - in_ready=1 from the first cycle after release.
- Stage k (0..NSTG-1): computes g/p for bits [k*GROUP +: GROUP] and full lookahead carries within the slice from its registered carry-in. Stage 0 carry-in is cin, or 1 when sub=1.
- Each stage registers:
  - completed low sum bits;
  - remaining high operand bits (B already inverted when sub=1);
  - slice carry-out;
  - valid bit.
- The last stage registers sum, cout, ovf and zero into the output register.
- Latency: operands accepted at edge t appear with out_valid=1 after edge t+NSTG-1; NSTG register stages in total, output register included.
- Advance enable: adv = !out_valid | out_ready. All stages shift together when adv=1 and hold otherwise. Bubbles are not collapsed.
- in_ready = adv, a combinational function of out_valid and out_ready. A transfer occurs on in_valid & in_ready.
  - in_valid=0 while adv=1 injects a bubble (stage-0 valid=0).
- Output handshake:
  - Result transfers on out_valid & out_ready.
  - While out_valid=1 & out_ready=0, sum/cout/ovf/zero are held stable and no stage changes.
- Simultaneous accept and drain in one cycle is legal and sustains 1 op/cycle.
- Results leave in acceptance order.
- Wrap-around: sum is modulo 2^WIDTH; the carry beyond WIDTH appears only on cout.
- Reset mid-operation discards all in-flight operations; none reach the output after release.
- NSTG=1 (WIDTH==GROUP): a single registered stage, latency 1, same handshake rules.
- Lookahead inside each slice is flat: no ripple across bits within a stage. The critical path is one slice plus the output flags.

Optional Feature:
- Macro CLA_PIPE_SAT_EN.
- Defined:
  - Adds input port sat (1 bit), carried down the pipeline alongside the operands.
  - When sat=1 and ovf=1, sum is clamped to signed max (0x7FFF for WIDTH=16) if the A operand sign was 0, else to signed min (0x8000).
  - ovf still reports 1. cout and zero reflect the clamped/unclamped values as follows: cout unclamped, zero from the clamped sum.
- Undefined: no sat port; sum always wraps.

Test Plan:
- WIDTH=16, GROUP=4: a=0x00FF, b=0x0001, cin=0, sub=0 -> after 4 cycles sum=0x0100, cout=0, ovf=0, zero=0.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, zero=1, ovf=0. This is a full-width propagate across all stages.
- Overflow and saturation:
  - a=0x7FFF, b=0x0001 add -> sum=0x8000, ovf=1.
  - With CLA_PIPE_SAT_EN and sat=1 -> sum=0x7FFF, ovf=1.
- Subtract:
  - sub=1, a=0x0000, b=0x0001 -> sum=0xFFFF, cout=0, ovf=0.
  - sub=1, a=0x1234, b=0x1234 -> sum=0, cout=1, zero=1.
- Back-pressure:
  - 6 back-to-back ops with out_ready=1 -> out_valid high 6 consecutive cycles, in order.
  - Then hold out_ready=0 for 3 cycles with a valid output -> in_ready=0, outputs unchanged; release -> stream resumes without loss or duplication.
- Reset and random check:
  - Pulse rst_n low while 3 ops are in flight -> out_valid=0 immediately; no stale results after release; in_ready=1 next cycle.
  - Then 10k random ops with random valid/ready, checked against a behavioural A±B model.
